// File: rtl/cla_word_sequencer_pkg.sv
// cla_word_sequencer_pkg: shared FSM encoding, slice width and index-width helper
package cla_word_sequencer_pkg;
  localparam int SLICE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cla_word_sequencer_cla8_slice.sv
// cla8_slice: 8-bit generate/propagate carry-lookahead adder (a, b, cin -> sum, cout)
module cla8_slice
  import cla_word_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W-1:0] g, p;
  logic [SLICE_W:0] c;
  logic pr;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    c = '0;
    pr = 1'b1;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      pr = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (g[j] & pr);
        pr = pr & p[j];
      end
      c[i+1] = c[i+1] | (cin & pr);
    end
  end
  assign sum = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];
endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: byte-serial word adder over one shared cla8_slice, valid/ready in and out; CLA_SEQ_SUB_EN adds the sub port
module cla_word_sequencer
  import cla_word_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SLICE_W*NBYTES-1:0]   op_a,
  input  logic [SLICE_W*NBYTES-1:0]   op_b,
  input  logic                        cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                        sub,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SLICE_W*NBYTES-1:0]   sum,
  output logic                        cout,
  output logic                        ovf
);
  localparam int W = SLICE_W * NBYTES;
  localparam int IW = clog2(NBYTES);
  state_t state_q;
  logic [W-1:0] a_q, b_q, sum_q;
  logic [IW-1:0] idx_q;
  logic c_q, cout_q, ovf_q, sub_w, last, s_co;
  logic [SLICE_W-1:0] s_sum;
`ifdef CLA_SEQ_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif
  assign last = idx_q == IW'(NBYTES - 1);
  cla8_slice u_slice (
    .a   (a_q[SLICE_W*idx_q +: SLICE_W]),
    .b   (b_q[SLICE_W*idx_q +: SLICE_W]),
    .cin (c_q),
    .sum (s_sum),
    .cout(s_co)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
      c_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q <= op_a;
          b_q <= sub_w ? ~op_b : op_b;
          c_q <= sub_w | cin;
          idx_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[SLICE_W*idx_q +: SLICE_W] <= s_sum;
          c_q <= s_co;
          idx_q <= last ? '0 : idx_q + 1'b1;
          if (last) begin
            cout_q <= s_co;
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (s_sum[SLICE_W-1] != a_q[W-1]);
            state_q <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: directed self-checking bench for cla_word_sequencer (NBYTES=4)
module tb_cla_word_sequencer;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic in_ready, out_valid, cout, ovf;
  logic [31:0] sum;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cla_word_sequencer #(.NBYTES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );
  task automatic run_op(input logic [31:0] a, b, input logic c, s, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; in_valid = 1; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0; in_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0})
      begin fails++; $display("FAIL reset: rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 0 0 0", in_ready, out_valid, sum, cout, ovf); end
    in_valid = 0; rst_n = 1;
  endtask
  task automatic test_carry_chain();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h0 || cout !== 1'b1 || ovf !== 1'b0)
      begin fails++; $display("FAIL carry_chain: lat=%0d sum=%h cout=%b ovf=%b want 4 00000000 1 0", lat, sum, cout, ovf); end
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin fails++; $display("FAIL carry_release: rdy=%b vld=%b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1)
      begin fails++; $display("FAIL overflow: lat=%0d sum=%h cout=%b ovf=%b want 4 80000000 0 1", lat, sum, cout, ovf); end
    release_out();
  endtask
  task automatic test_hold();
    int lat;
    run_op(32'h0000_00FF, 32'h0, 1'b1, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h0000_0100 || cout !== 1'b0 || ovf !== 1'b0)
      begin fails++; $display("FAIL cin_add: lat=%0d sum=%h cout=%b ovf=%b want 4 00000100 0 0", lat, sum, cout, ovf); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 32'h0000_0100)
        begin fails++; $display("FAIL hold%0d: vld=%b rdy=%b sum=%h want 1 0 00000100", i, out_valid, in_ready, sum); end
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin fails++; $display("FAIL hold_release: vld=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask
`ifdef CLA_SEQ_SUB_EN
  task automatic test_sub();
    int lat;
    run_op(32'h5, 32'h7, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || sum !== 32'hFFFF_FFFE || cout !== 1'b0 || ovf !== 1'b0)
      begin fails++; $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b want 4 fffffffe 0 0", lat, sum, cout, ovf); end
    release_out();
    run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h7FFF_FFFF || cout !== 1'b1 || ovf !== 1'b1)
      begin fails++; $display("FAIL sub_ovf: lat=%0d sum=%h cout=%b ovf=%b want 4 7fffffff 1 1", lat, sum, cout, ovf); end
    release_out();
  endtask
`endif
  task automatic test_reset_mid();
    int lat;
    logic seen;
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; cin = 0; sub = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'h0)
      begin fails++; $display("FAIL reset_mid: rdy=%b vld=%b sum=%h want 1 0 00000000", in_ready, out_valid, sum); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_novalid: out_valid seen=%b want 0", seen); end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 4 || sum !== 32'h2345_6789 || cout !== 1'b0 || ovf !== 1'b0)
      begin fails++; $display("FAIL after_reset: lat=%0d sum=%h cout=%b ovf=%b want 4 23456789 0 0", lat, sum, cout, ovf); end
    release_out();
  endtask
  task automatic test_back_to_back();
    logic [31:0] av [4] = '{32'h89AB_CDEF, 32'h4000_0000, 32'h8000_0000, 32'h0000_FFFF};
    logic [31:0] bv [4] = '{32'h7654_3211, 32'h4000_0000, 32'h8000_0000, 32'h00FF_0001};
    logic [33:0] exp_q [$];
    logic [33:0] e, ref_v;
    int k = 0, r = 0, last_acc = 0;
    out_ready = 1;
    for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
        tests++;
        if ({ovf, cout, sum} !== e)
          begin fails++; $display("FAIL b2b_result%0d: ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h", r, ovf, cout, sum, e[33], e[32], e[31:0]); end
        r++;
      end
      if (in_ready && k < 4) begin
        if (k > 0) begin
          tests++;
          if (cyc - last_acc !== 6)
            begin fails++; $display("FAIL b2b_interval%0d: got %0d cycles want 6", k, cyc - last_acc); end
        end
        last_acc = cyc;
        op_a = av[k]; op_b = bv[k]; cin = 0; sub = 0; in_valid = 1;
        ref_v[32:0] = {1'b0, av[k]} + {1'b0, bv[k]};
        ref_v[33] = (av[k][31] == bv[k][31]) && (ref_v[31] != av[k][31]);
        exp_q.push_back(ref_v);
        k++;
      end else if (k >= 4) in_valid = 0;
    end
    in_valid = 0; out_ready = 0;
    tests++;
    if (r !== 4) begin fails++; $display("FAIL b2b_count: got %0d results want 4", r); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_hold();
`ifdef CLA_SEQ_SUB_EN
    test_sub();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_word_sequencer.md
# cla_word_sequencer

- Multi-byte add controller that time-shares one 8-bit carry-lookahead adder slice.
- Accepts two NBYTES-wide operands over a valid/ready handshake and runs them through the slice one byte per cycle, least-significant byte first, chaining carry through a register.
- Presents the full-width sum, carry-out and signed overflow on a valid/ready output port.
- Sits between the operand source and the result consumer wherever word arithmetic wider than 8 bits is needed without replicating the adder.

## Interface
- NBYTES, 4, operand width in bytes (≥2); word width W = 8*NBYTES
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  operand request
- in_ready  output  1  sequencer idle, can accept
- op_a  input  W  operand A
- op_b  input  W  operand B
- cin  input  1  carry into byte 0
- sub  input  1  subtract request (present only with CLA_SEQ_SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result word
- cout  output  1  carry out of MSB
- ovf  output  1  two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- **IDLE**
  - On in_valid && in_ready at a clock edge: latch op_a and op_b into an operand register.
  - Carry register ← cin (or 1 when subtracting); byte index ← 0; go to RUN.
  - op_a, op_b and cin are ignored at all other times.
- **RUN**, each cycle:
  - Slice adds byte[idx] of A and effective B with the carry register.
  - Slice sum is written into sum[8*idx +: 8]; carry register ← slice cout; idx ← idx+1.
  - After byte NBYTES-1: register cout, compute ovf, go to DONE.
- **ovf** = (A_msb == Beff_msb) && (sum_msb != A_msb), where Beff is the B operand after optional inversion.
- **DONE**
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE.
- Index wrap: idx counts 0..NBYTES-1 only and is cleared on acceptance. No modular wrap is observable.
- **Reset values** (on the first edge with rst_n=0): state=IDLE, in_ready=1 after that edge, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry register=0.
- **Reset mid-operation** (RUN or DONE): the operation is abandoned, no out_valid is produced, and outputs return to reset values. in_valid is ignored while rst_n=0.
- **Simultaneous events**: out_ready in DONE and in_valid in the same cycle — the input is not accepted, because in_ready=0. It is accepted in the following IDLE cycle.

## Timing
- Acceptance edge E0. Byte i is registered at edge E(i+1).
- out_valid rises after edge E(NBYTES), i.e. NBYTES cycles after acceptance.
- Output handshake at edge Ed; in_ready=1 in the cycle after Ed.
- Minimum issue interval: NBYTES+2 cycles.
- Slice path is combinational within one cycle. No combinational path from in_valid or out_ready to any output except through state.

## Configuration
- CLA_SEQ_SUB_EN
  - **Defined**: `sub` port exists. sub is sampled at acceptance; when 1, Beff = ~op_b and the initial carry is 1, with cin ignored. cout=1 means no borrow.
  - **Undefined**: no `sub` port; Beff = op_b and the initial carry is cin.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, DONE) and its encoding;
  - localparam SLICE_W = 8;
  - the index width function clog2(NBYTES).
- One sub-module, **cla8_slice**: the 8-bit generate/propagate lookahead adder with ports a, b, cin, sum, cout. It is instantiated once; all sequencing stays in the top level.

## Test plan
- NBYTES=4, A=0xFFFFFFFF, B=0x00000001, cin=0 → sum=0x00000000, cout=1, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- A=0x7FFFFFFF, B=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1.
- A=0x000000FF, B=0, cin=1 → sum=0x00000100, cout=0, ovf=0. Then hold out_ready=0 for 3 cycles: sum is stable and in_ready=0 throughout. The result is released on the cycle out_ready=1.
- With CLA_SEQ_SUB_EN, sub=1, A=5, B=7 → sum=0xFFFFFFFE, cout=0, ovf=0. A=0x80000000, B=1 → sum=0x7FFFFFFF, ovf=1.
- Accept an operation, drive rst_n=0 for one edge while idx=2 → out_valid never asserts for that operation; in_ready=1 and sum=0 after the reset edge. A new request then completes normally.
- Back-to-back: in_valid held high with out_ready=1 → one acceptance every NBYTES+2 cycles, and results match a reference sum for random operands.
